// File: rtl/alap_if.sv
// alap_if: host handshake plus datapath control word between alap_ctrl and its datapath.
interface alap_if;
  logic start;
  logic stall;
  logic busy;
  logic done;
  logic in0_oe;
  logic in1_oe;
  logic f1_oe;
  logic f2_oe;
  logic out_oe;
  logic r2_sel;
  logic r1_en;
  logic r2_en;
  logic r3_en;
  logic [3:0] f1_f;
  logic [1:0] f2_f;
  modport master (
    input  start, stall,
    output busy, done, in0_oe, in1_oe, f1_oe, f2_oe, out_oe, r2_sel,
           r1_en, r2_en, r3_en, f1_f, f2_f
  );
  modport slave (
    output start, stall,
    input  busy, done, in0_oe, in1_oe, f1_oe, f2_oe, out_oe, r2_sel,
           r1_en, r2_en, r3_en, f1_f, f2_f
  );
endinterface

// File: rtl/alap_ctrl.sv
// alap_ctrl: Moore sequencer for the ALAP datapath: LOAD, ITERS x (S1,S2), S3, OUT.
module alap_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITERS = 1
) (
  input logic clk,
  input logic rst,
  alap_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, S1 = 3'd2, S2 = 3'd3, S3 = 3'd4, OUT = 3'd5;
  localparam logic [7:0] LAST = 8'(ITERS - 1);
  if (ITERS < 1 || ITERS > 255 || WIDTH < 1) begin : g_bad_param
    $error("alap_ctrl: ITERS must be 1..255 and WIDTH positive");
  end
  logic [2:0] state, nxt;
  logic [7:0] cnt;
  logic go, ld, s1, s2, s3, o;
  always_comb begin
    case (state)
      IDLE:    nxt = bus.start ? LOAD : IDLE;
      LOAD:    nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = (cnt != LAST) ? S1 : S3;
      S3:      nxt = OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!bus.stall) begin
      state <= nxt;
      if (state == LOAD) cnt <= '0;
      else if (state == S2 && cnt != LAST) cnt <= cnt + 8'd1;
    end
  end
  assign go = !bus.stall;
  assign ld = state == LOAD;
  assign s1 = state == S1;
  assign s2 = state == S2;
  assign s3 = state == S3;
  assign o  = state == OUT;
  // Stall gates every side-effecting strobe; selects and function codes stay put.
  assign bus.busy   = ld | s1 | s2 | s3 | o;
  assign bus.done   = go & o;
  assign bus.out_oe = go & o;
  assign bus.in0_oe = go & ld;
  assign bus.in1_oe = go & ld;
  assign bus.f1_oe  = go & (s1 | s2 | s3);
  assign bus.f2_oe  = go & s1;
  assign bus.r1_en  = go & (ld | s2 | s3);
  assign bus.r2_en  = go & (ld | s1 | s2);
  assign bus.r3_en  = go & (ld | s1);
  assign bus.r2_sel = s2;
  assign bus.f1_f   = s1 ? 4'h1 : s2 ? 4'h2 : s3 ? 4'h3 : 4'h0;
  assign bus.f2_f   = s1 ? 2'd1 : 2'd0;
endmodule

// File: doc/alap_ctrl.md
# alap_ctrl

Control unit for the ALAP-scheduled datapath. It sequences one computation: load operands, run ITERS passes of a two-step F1/F2 loop body, then one final F1 step. For every cycle it drives the datapath's tri-state enables, register enables, R2 mux select and function codes, and it gives the host a start/busy/done handshake. It sits directly upstream of the datapath: every output except `busy`/`done` wires one-to-one onto the same-named datapath input.

## Interface
- `WIDTH`, 32: datapath width. Not used internally; kept for uniform instantiation.
- `ITERS`, 1: number of loop-body passes (S1,S2). Legal range 1..255.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a computation. Sampled only in IDLE.
- `stall` input 1: freeze the sequence. Sampled in every state.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in OUT, with out_oe; the result is valid on the datapath out in that cycle.
- `in0_oe`, `in1_oe` output 1 each: drive in0 onto bus1 / in1 onto bus2.
- `f1_oe`, `f2_oe` output 1 each: drive F1 result onto bus1 / F2 result onto bus2.
- `out_oe` output 1: drive r1 onto the datapath output.
- `r2_sel` output 1: R2 input select; 0 selects bus2, 1 selects bus1.
- `r1_en`, `r2_en`, `r3_en` output 1 each: register load enables.
- `f1_f` output 4: F1 function code.
- `f2_f` output 2: F2 function code.

## Operation
- State register encoding: IDLE=0, LOAD=1, S1=2, S2=3, S3=4, OUT=5. Codes 6 and 7 decode as IDLE and return to IDLE on the next edge.
- All control outputs are a Moore decode of the state register and `stall` only. There is no path from `start` to any output.
- Any output not listed for a state is 0 in that state.
- Control word per state:
  - IDLE: all outputs 0.
  - LOAD: in0_oe, in1_oe, r1_en, r2_en, r3_en; r2_sel=0. Result: r1=r3=in0, r2=in1.
  - S1: f1_oe, f1_f=4'h1, r3_en; f2_oe, f2_f=2'd1, r2_en; r2_sel=0.
  - S2: f1_oe, f1_f=4'h2, r1_en, r2_en; r2_sel=1; f2_oe=0.
  - S3: f1_oe, f1_f=4'h3, r1_en.
  - OUT: out_oe, done.
- Transitions, evaluated only when stall=0:
  - IDLE→LOAD when start=1.
  - LOAD→S1.
  - S1→S2.
  - S2→S1 if cnt≠ITERS-1, otherwise S2→S3.
  - S3→OUT.
  - OUT→IDLE.
- Iteration counter `cnt`, width 8:
  - Cleared in LOAD.
  - Incremented on leaving S2 for S1.
  - Never wraps, because ITERS≤255.
- Stall: when stall=1, state and cnt hold. Every oe, en and done output is forced to 0. f1_f, f2_f and r2_sel keep their state values. busy is unaffected.
- Bus-conflict invariant, required in every cycle: never in0_oe&&f1_oe, never in1_oe&&f2_oe.
- start while busy is ignored and not queued. start held high through OUT starts a new run immediately after the return to IDLE.

## Timing
- Reset (asynchronous, any state, mid-run included): state=IDLE, cnt=0. All outputs 0 (busy=0, done=0) while rst is high and after it is released.
- start sampled high in IDLE at edge E puts the block in LOAD during cycle E+1.
- With no stall, done is high during cycle E+1+2·ITERS+2, i.e. E+5 for ITERS=1.
- Total busy cycles per run: 2·ITERS+3. Back-to-back runs are separated by exactly one IDLE cycle.
- Each stalled cycle extends the latency by exactly one cycle. Register updates happen only on non-stalled edges in the enable states.

## Test plan
- Reset, then start for one cycle with ITERS=1: states run LOAD,S1,S2,S3,OUT. done=1 exactly at start+5; busy high for 5 cycles; then IDLE with all outputs 0.
- ITERS=4: the S1/S2 pair repeats 4 times and done appears at start+11. Check f1_f values of 1,2,1,2,…,3 in sequence and r2_sel=1 only in S2.
- stall=1 for 3 cycles while in S1: state holds, all oe/en outputs=0, f1_f stays 1. done arrives 3 cycles late (start+8 for ITERS=1).
- start pulsed in S2 and held high through OUT: no effect mid-run. After OUT, exactly one IDLE cycle, then LOAD again.
- rst asserted asynchronously in the middle of S2: outputs go to 0 without waiting for a clock edge. After release the block stays in IDLE until a new start.
- Assertion over all runs, including random stall and start: in0_oe&f1_oe=0 and in1_oe&f2_oe=0 in every cycle, and done implies out_oe.
